// File: rtl/fir_out_fifo_pkg.sv
// Shared types and constants for the FIR output sample FIFO.
package fir_out_fifo_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } fifo_state_t;

    localparam int unsigned DROP_CNT_W = 16;
    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = 16'hFFFF;

    // Occupancy needs one more bit than the pointers so that "full" is representable.
    function automatic int unsigned level_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fir_out_fifo_if.sv
// Sample-in / stream-out / status bundle of the FIR output FIFO.
// The flush input exists only when FIR_OUT_FIFO_FLUSH_EN is defined.
interface fir_out_fifo_if
    import fir_out_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 16
) ();

    localparam int unsigned LEVEL_W = level_width(DEPTH);

    logic                         in_valid;
    logic signed [DATA_WIDTH-1:0] in_data;
    logic                         out_valid;
    logic                         out_ready;
    logic signed [DATA_WIDTH-1:0] out_data;
    logic [LEVEL_W-1:0]           level;
    logic                         empty;
    logic                         full;
    logic                         almost_full;
    logic                         overflow;
    logic [DROP_CNT_W-1:0]        drop_count;
    logic                         clr_overflow;
`ifdef FIR_OUT_FIFO_FLUSH_EN
    logic                         flush;
`endif

    // FIFO side
    modport slave (
`ifdef FIR_OUT_FIFO_FLUSH_EN
        input  flush,
`endif
        input  in_valid,
        input  in_data,
        input  out_ready,
        input  clr_overflow,
        output out_valid,
        output out_data,
        output level,
        output empty,
        output full,
        output almost_full,
        output overflow,
        output drop_count
    );

    // Producer / consumer / software side
    modport master (
`ifdef FIR_OUT_FIFO_FLUSH_EN
        output flush,
`endif
        output in_valid,
        output in_data,
        output out_ready,
        output clr_overflow,
        input  out_valid,
        input  out_data,
        input  level,
        input  empty,
        input  full,
        input  almost_full,
        input  overflow,
        input  drop_count
    );

endinterface

// File: rtl/fir_out_fifo_mem.sv
// Register-array storage: synchronous write port, asynchronous read port, no reset.
module fir_out_fifo_mem #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                         clk,
    input  logic                         i_wr_en,
    input  logic [$clog2(DEPTH)-1:0]     i_wr_addr,
    input  logic [DATA_WIDTH-1:0]        i_wr_data,
    input  logic [$clog2(DEPTH)-1:0]     i_rd_addr,
    output logic [DATA_WIDTH-1:0]        o_rd_data_c
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data_c = r_mem[i_rd_addr];

endmodule

// File: rtl/fir_out_fifo.sv
// Circular FWFT buffer for FIR output samples with overflow/drop accounting.
// Optional flush control is compiled in with FIR_OUT_FIFO_FLUSH_EN.
module fir_out_fifo
    import fir_out_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned AFULL_THRESH = 12
) (
    input  logic          clk,
    input  logic          rst,
    fir_out_fifo_if.slave bus
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned LEVEL_W = level_width(DEPTH);

    fifo_state_t           r_state;
    fifo_state_t           w_state_nxt;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [LEVEL_W-1:0]    r_level;
    logic                  r_overflow;
    logic [DROP_CNT_W-1:0] r_drop_count;

    logic                  w_run;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_out_valid;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic                  w_flush_now;
    logic [DATA_WIDTH-1:0] w_rd_data;

    // Status is decoded straight from the occupancy register.
    assign w_run       = (r_state == RUN);
    assign w_empty     = (r_level == '0);
    assign w_full      = (r_level == LEVEL_W'(DEPTH));
    assign w_out_valid = !w_empty && w_run;

    // The FIR cannot stall, so a full FIFO only makes room when the head leaves the same cycle.
    assign w_pop  = w_out_valid && bus.out_ready;
    assign w_push = w_run && bus.in_valid && (!w_full || w_pop);
    assign w_drop = w_run && bus.in_valid && w_full && !w_pop;

    // Next-state logic for the run/flush controller.
    always_comb begin
        w_state_nxt = r_state;
        w_flush_now = 1'b0;
`ifdef FIR_OUT_FIFO_FLUSH_EN
        if (r_state == FLUSH) begin
            w_state_nxt = RUN;
            w_flush_now = 1'b1;
        end else if (bus.flush) begin
            w_state_nxt = FLUSH;
        end
`else
        w_state_nxt = RUN;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Pointers and occupancy; a flush snaps the read side onto the write side.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (w_flush_now) begin
            r_rd_ptr <= r_wr_ptr;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + LEVEL_W'(1);
            end else if (w_pop && !w_push) begin
                r_level <= r_level - LEVEL_W'(1);
            end
        end
    end

    // Sticky overflow and saturating drop counter; a same-cycle drop beats a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (bus.clr_overflow) begin
                r_drop_count <= DROP_CNT_W'(1);
            end else if (r_drop_count != DROP_CNT_MAX) begin
                r_drop_count <= r_drop_count + DROP_CNT_W'(1);
            end
        end else if (bus.clr_overflow) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end
    end

    fir_out_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk         (clk),
        .i_wr_en     (w_push),
        .i_wr_addr   (r_wr_ptr),
        .i_wr_data   (bus.in_data),
        .i_rd_addr   (r_rd_ptr),
        .o_rd_data_c (w_rd_data)
    );

    assign bus.out_valid   = w_out_valid;
    assign bus.out_data    = w_rd_data;
    assign bus.level       = r_level;
    assign bus.empty       = w_empty;
    assign bus.full        = w_full;
    assign bus.almost_full = (r_level >= LEVEL_W'(AFULL_THRESH));
    assign bus.overflow    = r_overflow;
    assign bus.drop_count  = r_drop_count;

endmodule

// File: tb/tb_fir_out_fifo.sv
// Randomised bench for fir_out_fifo against a queue-based reference model.
module tb_fir_out_fifo;

    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AF    = 12;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    // Reference model state
    logic [DW-1:0] mq[$];
    bit            m_ovf;
    int            m_cnt;
    bit            m_flushing;

    fir_out_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    fir_out_fifo #(
        .DATA_WIDTH   (DW),
        .DEPTH        (DEPTH),
        .AFULL_THRESH (AF)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    // One clock of stimulus, applied at negedge; the model follows the FIFO rules at the edge.
    task automatic drive(input bit v, input logic [DW-1:0] d, input bit rdy,
                         input bit clr, input bit rs, input bit fl);
        bit pop, push, drop;
        bus.in_valid     = v;
        bus.in_data      = d;
        bus.out_ready    = rdy;
        bus.clr_overflow = clr;
        rst              = rs;
`ifdef FIR_OUT_FIFO_FLUSH_EN
        bus.flush        = fl;
`endif
        pop  = !m_flushing && (mq.size() > 0) && rdy;
        push = !m_flushing && v && ((mq.size() < DEPTH) || pop);
        drop = !m_flushing && v && (mq.size() == DEPTH) && !pop;
        @(posedge clk);
        if (rs) begin
            mq.delete();
            m_ovf      = 1'b0;
            m_cnt      = 0;
            m_flushing = 1'b0;
        end else begin
            if (m_flushing) begin
                mq.delete();
                m_flushing = 1'b0;
            end else begin
                if (pop) void'(mq.pop_front());
                if (push) mq.push_back(d);
                if (fl) m_flushing = 1'b1;
            end
            if (drop) begin
                m_ovf = 1'b1;
                m_cnt = clr ? 1 : ((m_cnt < 65535) ? m_cnt + 1 : 65535);
            end else if (clr) begin
                m_ovf = 1'b0;
                m_cnt = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(0, '0, 0, 0, 1, 0);
        drive(0, '0, 0, 0, 1, 0);
        drive(0, '0, 0, 0, 0, 0);
        checks++; if (bus.level !== 5'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", bus.level); end
        checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", bus.empty); end
        checks++; if (bus.full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", bus.full); end
        checks++; if (bus.almost_full !== 1'b0) begin failures++; $display("FAIL reset_afull got=%b exp=0", bus.almost_full); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", bus.overflow); end
        checks++; if (bus.drop_count !== 16'd0) begin failures++; $display("FAIL reset_drop_count got=%0d exp=0", bus.drop_count); end
    endtask

    task automatic test_basic();
        logic [DW-1:0] exp_v[3];
        exp_v[0] = 16'd100;
        exp_v[1] = 16'(-200);
        exp_v[2] = 16'd300;
        for (int i = 0; i < 3; i++) drive(1, exp_v[i], 0, 0, 0, 0);
        checks++; if (bus.level !== 5'd3) begin failures++; $display("FAIL basic_level got=%0d exp=3", bus.level); end
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", bus.out_valid); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.out_data !== exp_v[i]) begin
                failures++; $display("FAIL basic_order[%0d] got=%0d exp=%0d", i, bus.out_data, $signed(exp_v[i]));
            end
            drive(0, '0, 1, 0, 0, 0);
        end
        checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL basic_empty got=%b exp=1", bus.empty); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL basic_drained_valid got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_fill_overflow();
        for (int i = 1; i <= DEPTH; i++) begin
            drive(1, DW'($urandom), 0, 0, 0, 0);
            checks++; if (bus.level !== 5'(i)) begin failures++; $display("FAIL fill_level got=%0d exp=%0d", bus.level, i); end
            checks++; if (bus.almost_full !== (i >= AF)) begin failures++; $display("FAIL fill_afull lvl=%0d got=%b exp=%b", i, bus.almost_full, (i >= AF)); end
            checks++; if (bus.full !== (i == DEPTH)) begin failures++; $display("FAIL fill_full lvl=%0d got=%b exp=%b", i, bus.full, (i == DEPTH)); end
        end
        for (int i = 0; i < 5; i++) drive(1, DW'($urandom), 0, 0, 0, 0);
        checks++; if (bus.overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", bus.overflow); end
        checks++; if (bus.drop_count !== 16'd5) begin failures++; $display("FAIL ovf_drop_count got=%0d exp=5", bus.drop_count); end
        checks++; if (bus.level !== 5'd16) begin failures++; $display("FAIL ovf_level got=%0d exp=16", bus.level); end
        checks++; if (bus.out_data !== mq[0]) begin failures++; $display("FAIL ovf_head got=%0h exp=%0h", bus.out_data, mq[0]); end
    endtask

    task automatic test_full_passthrough();
        for (int i = 0; i < 10; i++) begin
            checks++; if (bus.out_data !== mq[0]) begin failures++; $display("FAIL pass_data[%0d] got=%0h exp=%0h", i, bus.out_data, mq[0]); end
            drive(1, DW'($urandom), 1, 0, 0, 0);
            checks++; if (bus.level !== 5'd16) begin failures++; $display("FAIL pass_level got=%0d exp=16", bus.level); end
        end
        checks++; if (bus.drop_count !== 16'd5) begin failures++; $display("FAIL pass_drop_count got=%0d exp=5", bus.drop_count); end
        while (mq.size() > 0) begin
            checks++; if (bus.out_data !== mq[0]) begin failures++; $display("FAIL pass_drain got=%0h exp=%0h", bus.out_data, mq[0]); end
            drive(0, '0, 1, 0, 0, 0);
        end
        checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL pass_empty got=%b exp=1", bus.empty); end
    endtask

    task automatic test_clr_overflow();
        for (int i = 0; i < DEPTH; i++) drive(1, DW'($urandom), 0, 0, 0, 0);
        drive(1, DW'($urandom), 0, 1, 0, 0);
        checks++; if (bus.overflow !== 1'b1) begin failures++; $display("FAIL clr_race_ovf got=%b exp=1", bus.overflow); end
        checks++; if (bus.drop_count !== 16'd1) begin failures++; $display("FAIL clr_race_count got=%0d exp=1", bus.drop_count); end
        drive(0, '0, 0, 1, 0, 0);
        checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL clr_ovf got=%b exp=0", bus.overflow); end
        checks++; if (bus.drop_count !== 16'd0) begin failures++; $display("FAIL clr_count got=%0d exp=0", bus.drop_count); end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 70000; i++) drive(1, DW'($urandom), 0, 0, 0, 0);
        checks++; if (bus.drop_count !== 16'(m_cnt)) begin failures++; $display("FAIL sat_count got=%0d exp=%0d", bus.drop_count, m_cnt); end
        checks++; if (bus.drop_count !== 16'hFFFF) begin failures++; $display("FAIL sat_max got=%0d exp=65535", bus.drop_count); end
        checks++; if (bus.level !== 5'd16) begin failures++; $display("FAIL sat_level got=%0d exp=16", bus.level); end
        drive(0, '0, 0, 1, 0, 0);
    endtask

    task automatic test_random();
        bit v, rdy, clr;
        for (int i = 0; i < 800; i++) begin
            checks++; if (bus.level !== 5'(mq.size())) begin failures++; $display("FAIL rnd_level c=%0d got=%0d exp=%0d", i, bus.level, mq.size()); end
            checks++; if (bus.out_valid !== (mq.size() > 0)) begin failures++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", i, bus.out_valid, (mq.size() > 0)); end
            checks++; if (bus.almost_full !== (mq.size() >= AF)) begin failures++; $display("FAIL rnd_afull c=%0d got=%b", i, bus.almost_full); end
            checks++; if (bus.full !== (mq.size() == DEPTH)) begin failures++; $display("FAIL rnd_full c=%0d got=%b", i, bus.full); end
            checks++; if (bus.empty !== (mq.size() == 0)) begin failures++; $display("FAIL rnd_empty c=%0d got=%b", i, bus.empty); end
            checks++; if (bus.overflow !== m_ovf) begin failures++; $display("FAIL rnd_ovf c=%0d got=%b exp=%b", i, bus.overflow, m_ovf); end
            checks++; if (bus.drop_count !== 16'(m_cnt)) begin failures++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", i, bus.drop_count, m_cnt); end
            if (mq.size() > 0) begin
                checks++; if (bus.out_data !== mq[0]) begin failures++; $display("FAIL rnd_data c=%0d got=%0h exp=%0h", i, bus.out_data, mq[0]); end
            end
            v   = ($urandom_range(0, 99) < 60);
            rdy = ($urandom_range(0, 99) < ((i / 200) % 2 == 0 ? 30 : 70));
            clr = ($urandom_range(0, 15) == 0);
            drive(v, DW'($urandom), rdy, clr, 0, 0);
        end
    endtask

    task automatic test_reset_mid();
        drive(0, '0, 0, 0, 1, 0);
        for (int i = 0; i < DEPTH + 1; i++) drive(1, DW'($urandom), 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) drive(0, '0, 1, 0, 0, 0);
        checks++; if (bus.level !== 5'd7) begin failures++; $display("FAIL mid_pre_level got=%0d exp=7", bus.level); end
        checks++; if (bus.overflow !== 1'b1) begin failures++; $display("FAIL mid_pre_ovf got=%b exp=1", bus.overflow); end
        drive(1, DW'($urandom), 0, 0, 1, 0);
        checks++; if (bus.level !== 5'd0) begin failures++; $display("FAIL mid_level got=%0d exp=0", bus.level); end
        checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL mid_empty got=%b exp=1", bus.empty); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL mid_ovf got=%b exp=0", bus.overflow); end
        drive(1, 16'h1234, 0, 0, 0, 0);
        checks++; if (bus.out_data !== 16'h1234) begin failures++; $display("FAIL mid_newhead got=%0h exp=1234", bus.out_data); end
        checks++; if (bus.level !== 5'd1) begin failures++; $display("FAIL mid_newlevel got=%0d exp=1", bus.level); end
    endtask

`ifdef FIR_OUT_FIFO_FLUSH_EN
    task automatic test_flush();
        drive(0, '0, 0, 0, 1, 0);
        for (int i = 0; i < 9; i++) drive(1, DW'($urandom), 0, 0, 0, 0);
        checks++; if (bus.level !== 5'd9) begin failures++; $display("FAIL fl_pre_level got=%0d exp=9", bus.level); end
        drive(0, '0, 0, 0, 0, 1);
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL fl_valid got=%b exp=0", bus.out_valid); end
        drive(1, DW'($urandom), 1, 0, 0, 1);
        checks++; if (bus.level !== 5'd0) begin failures++; $display("FAIL fl_level got=%0d exp=0", bus.level); end
        checks++; if (bus.drop_count !== 16'd0) begin failures++; $display("FAIL fl_count got=%0d exp=0", bus.drop_count); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL fl_after_valid got=%b exp=0", bus.out_valid); end
        drive(1, 16'h0BEE, 0, 0, 0, 0);
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL fl_resume_valid got=%b exp=1", bus.out_valid); end
        checks++; if (bus.out_data !== 16'h0BEE) begin failures++; $display("FAIL fl_resume_data got=%0h exp=0bee", bus.out_data); end
    endtask
`endif

    initial begin
        checks           = 0;
        failures         = 0;
        m_ovf            = 1'b0;
        m_cnt            = 0;
        m_flushing       = 1'b0;
        rst              = 1'b1;
        bus.in_valid     = 1'b0;
        bus.in_data      = '0;
        bus.out_ready    = 1'b0;
        bus.clr_overflow = 1'b0;
`ifdef FIR_OUT_FIFO_FLUSH_EN
        bus.flush        = 1'b0;
`endif
        @(negedge clk);
        test_reset();
        test_basic();
        test_fill_overflow();
        test_full_passthrough();
        test_clr_overflow();
        test_saturate();
        test_random();
        test_reset_mid();
`ifdef FIR_OUT_FIFO_FLUSH_EN
        test_flush();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
